// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding,
// timeout counter width and the MEM/WB bundle with its bubble values.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  regsel;
    logic        reg_write;
    logic        halt;
    logic        valid;
    logic        err;
  } wb_t;

  localparam wb_t BUBBLE     = '0;
  localparam wb_t ERR_BUBBLE = '{data: 16'h0000, regsel: 3'b000, reg_write: 1'b0,
                                 halt: 1'b1, valid: 1'b0, err: 1'b1};

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory handshake FSM: request/stall generation, timeout counter and,
// when MEM_ALIGN_CHECK_EN is defined, rejection of odd addresses.
module dmem_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_op,
  input  logic addr_lsb,
  input  logic dmem_ready,
  output logic dmem_req,
  output logic stall,
  output logic take,
  output logic abort
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = addr_lsb;
`else
  // Bit 0 is deliberately ignored; the AND keeps the port formally used.
  assign misaligned = addr_lsb & 1'b0;
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    take     = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          take = 1'b1;
        end else if (misaligned) begin
          abort = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            take = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        // A late ready wins over the timeout in the same cycle.
        if (dmem_ready) begin
          dmem_req = mem_op;
          take     = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == TIMEOUT) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          dmem_req = mem_op;
          stall    = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      dmem_req = 1'b0;
      stall    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 16-bit pipeline: wraps dmem_ctrl with the write-back mux
// and the MEM/WB register. Optional odd-address trap: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] aluResult_in,
  input  logic [15:0] B_in,
  input  logic [15:0] nextPC_in,
  input  logic [15:0] newPC_in,
  input  logic [2:0]  regsel_in,
  input  logic        enJAL_in,
  input  logic        branch_in,
  input  logic        mem_to_reg_in,
  input  logic        memWrite_in,
  input  logic        regWrite_in,
  input  logic        halt_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        pc_redirect,
  output logic [15:0] pc_target,
  output logic [15:0] wbData_out,
  output logic [2:0]  regsel_out,
  output logic        regWrite_out,
  output logic        halt_out,
  output logic        valid_out,
  output logic        err_out
);

  logic mem_op, take, abort;
  wb_t  wb_d, wb_q;

  assign mem_op     = valid_in & (mem_to_reg_in | memWrite_in);
  assign dmem_addr  = aluResult_in;
  assign dmem_wdata = B_in;
  assign dmem_we    = memWrite_in;

  assign pc_redirect = valid_in & branch_in & ~rst;
  assign pc_target   = newPC_in;

  dmem_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .mem_op     (mem_op),
    .addr_lsb   (aluResult_in[0]),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .stall      (stall),
    .take       (take),
    .abort      (abort)
  );

  always_comb begin
    wb_d = BUBBLE;
    if (abort) begin
      wb_d = ERR_BUBBLE;
    end else if (take && valid_in) begin
      wb_d.data      = enJAL_in      ? nextPC_in  :
                       mem_to_reg_in ? dmem_rdata : aluResult_in;
      wb_d.regsel    = regsel_in;
      wb_d.reg_write = regWrite_in;
      wb_d.halt      = halt_in;
      wb_d.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wb_q <= BUBBLE;
    else     wb_q <= wb_d;
  end

  assign wbData_out   = wb_q.data;
  assign regsel_out   = wb_q.regsel;
  assign regWrite_out = wb_q.reg_write;
  assign halt_out     = wb_q.halt;
  assign valid_out    = wb_q.valid;
  assign err_out      = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT_CYC = 4); inputs change
// 1 ns after the rising edge, combinational outputs are sampled 1 ns later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] aluResult_in, B_in, nextPC_in, newPC_in;
  logic [2:0]  regsel_in;
  logic        enJAL_in, branch_in, mem_to_reg_in, memWrite_in, regWrite_in, halt_in;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;
  logic        stall, pc_redirect;
  logic [15:0] pc_target, wbData_out;
  logic [2:0]  regsel_out;
  logic        regWrite_out, halt_out, valid_out, err_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .aluResult_in(aluResult_in),
    .B_in(B_in), .nextPC_in(nextPC_in), .newPC_in(newPC_in), .regsel_in(regsel_in),
    .enJAL_in(enJAL_in), .branch_in(branch_in), .mem_to_reg_in(mem_to_reg_in),
    .memWrite_in(memWrite_in), .regWrite_in(regWrite_in), .halt_in(halt_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .wbData_out(wbData_out), .regsel_out(regsel_out), .regWrite_out(regWrite_out),
    .halt_out(halt_out), .valid_out(valid_out), .err_out(err_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; aluResult_in = 0; B_in = 0; nextPC_in = 0; newPC_in = 0;
    regsel_in = 0; enJAL_in = 0; branch_in = 0; mem_to_reg_in = 0;
    memWrite_in = 0; regWrite_in = 0; halt_in = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    valid_in = 1; mem_to_reg_in = 1; branch_in = 1; regWrite_in = 1; halt_in = 1;
    aluResult_in = 16'h5A5A; regsel_in = 3'd6; newPC_in = 16'h0200;
    cyc();
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %b want 0", pc_redirect); end
    cyc();
    n_cmp++; if ({wbData_out, regsel_out, regWrite_out, halt_out, valid_out, err_out} !== 23'd0) begin
      n_bad++; $display("FAIL reset_regs: got %h/%0d/%b%b%b%b want all 0",
                        wbData_out, regsel_out, regWrite_out, halt_out, valid_out, err_out);
    end
    clear_inputs();
    rst = 0;
    cyc();
  endtask

  task automatic test_alu();
    clear_inputs();
    valid_in = 1; aluResult_in = 16'h1234; regsel_in = 3'd3; regWrite_in = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stall); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL alu_req: got %b want 0", dmem_req); end
    cyc();
    n_cmp++; if (wbData_out !== 16'h1234) begin n_bad++; $display("FAIL alu_data: got %h want 1234", wbData_out); end
    n_cmp++; if (regsel_out !== 3'd3) begin n_bad++; $display("FAIL alu_regsel: got %0d want 3", regsel_out); end
    n_cmp++; if ({regWrite_out, valid_out, err_out} !== 3'b110) begin
      n_bad++; $display("FAIL alu_ctrl: got rw/v/err %b%b%b want 110", regWrite_out, valid_out, err_out);
    end
  endtask

  task automatic test_load_wait();
    clear_inputs();
    valid_in = 1; mem_to_reg_in = 1; regWrite_in = 1; regsel_in = 3'd5; aluResult_in = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({dmem_req, stall, dmem_we} !== 3'b110) begin
        n_bad++; $display("FAIL load_wait_cyc%0d: got req/stall/we %b%b%b want 110", k, dmem_req, stall, dmem_we);
      end
      n_cmp++; if (dmem_addr !== 16'h0040) begin n_bad++; $display("FAIL load_addr_cyc%0d: got %h want 0040", k, dmem_addr); end
      cyc();
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL load_bubble_cyc%0d: got valid %b want 0", k, valid_out); end
    end
    dmem_ready = 1; dmem_rdata = 16'hBEEF;
    #1;
    n_cmp++; if ({dmem_req, stall} !== 2'b10) begin
      n_bad++; $display("FAIL load_ready_cyc: got req/stall %b%b want 10", dmem_req, stall);
    end
    cyc();
    n_cmp++; if (wbData_out !== 16'hBEEF) begin n_bad++; $display("FAIL load_data: got %h want beef", wbData_out); end
    n_cmp++; if ({valid_out, regWrite_out, regsel_out} !== 5'b11_101) begin
      n_bad++; $display("FAIL load_ctrl: got v/rw/rs %b/%b/%0d want 1/1/5", valid_out, regWrite_out, regsel_out);
    end
    clear_inputs();
  endtask

  task automatic test_store();
    clear_inputs();
    valid_in = 1; memWrite_in = 1; aluResult_in = 16'h0010; B_in = 16'h00AA;
    regsel_in = 3'd2; dmem_ready = 1;
    #1;
    n_cmp++; if ({dmem_req, dmem_we, stall} !== 3'b110) begin
      n_bad++; $display("FAIL store_hs: got req/we/stall %b%b%b want 110", dmem_req, dmem_we, stall);
    end
    n_cmp++; if (dmem_wdata !== 16'h00AA) begin n_bad++; $display("FAIL store_wdata: got %h want 00aa", dmem_wdata); end
    cyc();
    n_cmp++; if ({valid_out, regWrite_out, err_out} !== 3'b100) begin
      n_bad++; $display("FAIL store_wb: got v/rw/err %b%b%b want 100", valid_out, regWrite_out, err_out);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    valid_in = 1; mem_to_reg_in = 1; regWrite_in = 1; regsel_in = 3'd1; aluResult_in = 16'h0080;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({dmem_req, stall} !== 2'b11) begin
        n_bad++; $display("FAIL timeout_wait_cyc%0d: got req/stall %b%b want 11", k, dmem_req, stall);
      end
      cyc();
      n_cmp++; if ({valid_out, err_out} !== 2'b00) begin
        n_bad++; $display("FAIL timeout_bubble_cyc%0d: got v/err %b%b want 00", k, valid_out, err_out);
      end
    end
    #1;
    n_cmp++; if ({dmem_req, stall} !== 2'b00) begin
      n_bad++; $display("FAIL timeout_drop: got req/stall %b%b want 00", dmem_req, stall);
    end
    cyc();
    n_cmp++; if ({err_out, halt_out, valid_out, regWrite_out} !== 4'b1100) begin
      n_bad++; $display("FAIL timeout_err: got err/halt/v/rw %b%b%b%b want 1100", err_out, halt_out, valid_out, regWrite_out);
    end
    clear_inputs();
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_idle_req: got %b want 0", dmem_req); end
    cyc();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    valid_in = 1; mem_to_reg_in = 1; regWrite_in = 1; aluResult_in = 16'h0100;
    cyc();
    rst = 1;
    #1;
    n_cmp++; if ({dmem_req, stall} !== 2'b00) begin
      n_bad++; $display("FAIL rstwait_force: got req/stall %b%b want 00", dmem_req, stall);
    end
    dmem_ready = 1; dmem_rdata = 16'hDEAD;
    cyc();
    n_cmp++; if ({valid_out, regWrite_out, wbData_out} !== 18'd0) begin
      n_bad++; $display("FAIL rstwait_wb: got v/rw/data %b%b%h want 0", valid_out, regWrite_out, wbData_out);
    end
    rst = 0;
    clear_inputs();
    valid_in = 1; aluResult_in = 16'h0F0F; regsel_in = 3'd4; regWrite_in = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstwait_idle_stall: got %b want 0", stall); end
    cyc();
    n_cmp++; if (wbData_out !== 16'h0F0F) begin n_bad++; $display("FAIL rstwait_resume: got %h want 0f0f", wbData_out); end
    clear_inputs();
  endtask

  task automatic test_control_flow();
    clear_inputs();
    valid_in = 1; enJAL_in = 1; nextPC_in = 16'h0022; aluResult_in = 16'h5555;
    regWrite_in = 1; regsel_in = 3'd7;
    cyc();
    n_cmp++; if (wbData_out !== 16'h0022) begin n_bad++; $display("FAIL jal_data: got %h want 0022", wbData_out); end
    n_cmp++; if (regsel_out !== 3'd7) begin n_bad++; $display("FAIL jal_regsel: got %0d want 7", regsel_out); end
    clear_inputs();
    valid_in = 1; branch_in = 1; newPC_in = 16'h0100;
    #1;
    n_cmp++; if (pc_redirect !== 1'b1) begin n_bad++; $display("FAIL br_redirect: got %b want 1", pc_redirect); end
    n_cmp++; if (pc_target !== 16'h0100) begin n_bad++; $display("FAIL br_target: got %h want 0100", pc_target); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL br_stall: got %b want 0", stall); end
    valid_in = 0;
    #1;
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL br_invalid: got %b want 0", pc_redirect); end
    cyc();
  endtask

  task automatic test_invalid_and_halt();
    clear_inputs();
    mem_to_reg_in = 1; regWrite_in = 1; aluResult_in = 16'h0044;
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL inv_req: got %b want 0", dmem_req); end
    cyc();
    n_cmp++; if ({valid_out, regWrite_out} !== 2'b00) begin
      n_bad++; $display("FAIL inv_bubble: got v/rw %b%b want 00", valid_out, regWrite_out);
    end
    clear_inputs();
    valid_in = 1; halt_in = 1; aluResult_in = 16'h0001;
    cyc();
    n_cmp++; if ({halt_out, err_out, valid_out} !== 3'b101) begin
      n_bad++; $display("FAIL halt_pass: got halt/err/v %b%b%b want 101", halt_out, err_out, valid_out);
    end
    clear_inputs();
  endtask

  task automatic test_align();
    clear_inputs();
    valid_in = 1; mem_to_reg_in = 1; regWrite_in = 1; regsel_in = 3'd2; aluResult_in = 16'h0041;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    n_cmp++; if ({dmem_req, stall} !== 2'b00) begin
      n_bad++; $display("FAIL align_noreq: got req/stall %b%b want 00", dmem_req, stall);
    end
    cyc();
    n_cmp++; if ({err_out, halt_out, valid_out} !== 3'b110) begin
      n_bad++; $display("FAIL align_err: got err/halt/v %b%b%b want 110", err_out, halt_out, valid_out);
    end
`else
    dmem_ready = 1; dmem_rdata = 16'h1357;
    #1;
    n_cmp++; if ({dmem_req, dmem_addr} !== {1'b1, 16'h0041}) begin
      n_bad++; $display("FAIL odd_addr_req: got req/addr %b/%h want 1/0041", dmem_req, dmem_addr);
    end
    cyc();
    n_cmp++; if ({wbData_out, err_out} !== {16'h1357, 1'b0}) begin
      n_bad++; $display("FAIL odd_addr_data: got %h/err %b want 1357/0", wbData_out, err_out);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    valid_in = 1; regWrite_in = 1; aluResult_in = 16'hA001; regsel_in = 3'd1;
    cyc();
    n_cmp++; if (wbData_out !== 16'hA001) begin n_bad++; $display("FAIL b2b_first: got %h want a001", wbData_out); end
    aluResult_in = 16'hA002; regsel_in = 3'd2;
    cyc();
    n_cmp++; if ({wbData_out, regsel_out} !== {16'hA002, 3'd2}) begin
      n_bad++; $display("FAIL b2b_second: got %h/%0d want a002/2", wbData_out, regsel_out);
    end
    clear_inputs();
    cyc();
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", valid_out); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #1;
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_timeout();
    test_reset_mid_wait();
    test_control_flow();
    test_invalid_and_halt();
    test_align();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
